// File: rtl/object_sprite_renderer_pkg.sv
// vga_pkg: raster geometry and object display-mode encoding shared by the sprite renderer.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W = 10;
  typedef enum logic [1:0] {HIDDEN = 2'd0, THUMB = 2'd1, FULL = 2'd2} mode_t;
  function automatic mode_t next_mode(input logic full_screen, input logic sprite_select);
    return !full_screen ? THUMB : sprite_select ? FULL : HIDDEN;
  endfunction
endpackage

// File: rtl/object_sprite_renderer_blink.sv
// object_blink_ctrl: frame-counted blink visibility, changing only on frame_start.
module object_blink_ctrl #(
  parameter int BLINK_FR = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic blink_en,
  output logic blink_vis
);
  logic [7:0] r_cnt;
  logic       r_vis;
  logic       w_wrap;
  assign w_wrap = r_cnt == 8'(BLINK_FR - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_vis <= 1'b1;
    end else if (!blink_en) begin
      r_cnt <= '0;
      r_vis <= 1'b1;
    end else if (frame_start) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 8'd1;
      r_vis <= w_wrap ? ~r_vis : r_vis;
    end
  assign blink_vis = r_vis;
endmodule

// File: rtl/object_sprite_renderer.sv
// object_sprite_renderer: 2-stage bitmap object renderer addressing an external sprite ROM.
module object_sprite_renderer
  import vga_pkg::*;
#(
  parameter int SPR_W      = 200,
  parameter int SPR_H      = 145,
  parameter int ADDR_W     = 8,
  parameter int THUMB_X    = 434,
  parameter int THUMB_Y    = 26,
  parameter int FULL_X     = 220,
  parameter int FULL_Y     = 172,
  parameter int FULL_SHIFT = 0,
  parameter int BLINK_FR   = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        HCount,
  input  logic [9:0]        VCount,
  input  logic              frame_start,
  input  logic              sprite_select,
  input  logic              full_screen,
  input  logic              blink_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [SPR_W-1:0]  rom_data,
  output logic              sprite_on
);
  localparam int COL_W = $clog2(SPR_W);
  mode_t             r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [COL_W-1:0]  r_col_q;
  logic              r_hit_q;
  logic              r_on;
  logic              w_blink_vis;
  logic              w_full;
  logic [1:0]        w_sh;
  logic [10:0]       w_x, w_y, w_right, w_bottom, w_h, w_v;
  logic              w_hit;
  logic [9:0]        w_dx, w_dy;
  logic [COL_W-1:0]  w_col;
  logic [ADDR_W-1:0] w_row;
  // 11-bit box edges let an oversized box clip at the raster edge instead of wrapping.
  always_comb begin
    w_full   = r_mode == FULL;
    w_x      = w_full ? 11'(FULL_X) : 11'(THUMB_X);
    w_y      = w_full ? 11'(FULL_Y) : 11'(THUMB_Y);
    w_sh     = w_full ? 2'(FULL_SHIFT) : 2'd0;
    w_right  = w_x + (11'(SPR_W) << w_sh) - 11'd1;
    w_bottom = w_y + (11'(SPR_H) << w_sh) - 11'd1;
    w_h      = {1'b0, HCount};
    w_v      = {1'b0, VCount};
    w_hit    = (r_mode != HIDDEN) && w_h >= w_x && w_h <= w_right && w_v >= w_y && w_v <= w_bottom;
    w_dx     = w_hit ? 10'(w_h - w_x) : '0;
    w_dy     = w_hit ? 10'(w_v - w_y) : '0;
    w_col    = COL_W'(w_dx >> w_sh);
    w_row    = ADDR_W'(w_dy >> w_sh);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mode  <= HIDDEN;
      r_addr  <= '0;
      r_col_q <= '0;
      r_hit_q <= 1'b0;
      r_on    <= 1'b0;
    end else begin
      r_mode  <= frame_start ? next_mode(full_screen, sprite_select) : r_mode;
      r_addr  <= w_hit ? w_row : r_addr;
      r_col_q <= w_col;
      r_hit_q <= w_hit;
      r_on    <= r_hit_q & rom_data[r_col_q] & w_blink_vis & (r_mode != HIDDEN);
    end
  object_blink_ctrl #(.BLINK_FR(BLINK_FR)) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .blink_en   (blink_en),
    .blink_vis  (w_blink_vis)
  );
  assign rom_addr  = r_addr;
  assign sprite_on = r_on;
endmodule

// File: tb/tb_object_sprite_renderer.sv
// tb_object_sprite_renderer: randomized scoreboard bench against a geometric reference model.
module tb_object_sprite_renderer;
  localparam int SPR_W = 200, SPR_H = 145, ADDR_W = 8;
  localparam int THUMB_X = 900, THUMB_Y = 26, FULL_X = 220, FULL_Y = 172;
  localparam int FULL_SHIFT = 1, BLINK_FR = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] HCount = '0, VCount = '0;
  logic frame_start = 1'b0, sprite_select = 1'b0, full_screen = 1'b0, blink_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [SPR_W-1:0] rom_data;
  logic sprite_on;
  logic [SPR_W-1:0] rom [SPR_H];

  int n_chk = 0, n_pass = 0;
  bit mon_en = 1'b0;
  int qa[$];
  bit qo[$];
  int m_mode = 0, m_bcnt = 0, m_addr = 0;
  bit m_bvis = 1'b1;

  always #5 clk = ~clk;

  assign rom_data = (int'(rom_addr) < SPR_H) ? rom[rom_addr] : '0;

  object_sprite_renderer #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .THUMB_X(THUMB_X), .THUMB_Y(THUMB_Y),
    .FULL_X(FULL_X), .FULL_Y(FULL_Y), .FULL_SHIFT(FULL_SHIFT), .BLINK_FR(BLINK_FR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .HCount(HCount), .VCount(VCount), .frame_start(frame_start),
    .sprite_select(sprite_select), .full_screen(full_screen), .blink_en(blink_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .sprite_on(sprite_on)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (H=%0d V=%0d t=%0t)", name, act, exp, HCount, VCount, $time);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (qa.size() >= 2) chk("rom_addr", int'(rom_addr), qa.pop_front());
    if (qo.size() >= 3) chk("sprite_on", int'(sprite_on), int'(qo.pop_front()));
  end

  task automatic rom_fill(input int kind);
    for (int r = 0; r < SPR_H; r++)
      for (int c = 0; c < SPR_W; c++)
        rom[r][c] = (kind == 0) ? 1'b1 : (kind == 2 && r == 0) ? (c == 0) : 1'($urandom_range(0, 1));
  endtask

  // One pixel per clock: model the expected response from box geometry, then advance frame state.
  task automatic pix(input int h, input int v, input bit fs);
    int x, y, sc;
    bit in_box, e_on;
    HCount = 10'(h);
    VCount = 10'(v);
    frame_start = fs;
    x = (m_mode == 2) ? FULL_X : THUMB_X;
    y = (m_mode == 2) ? FULL_Y : THUMB_Y;
    sc = (m_mode == 2) ? (1 << FULL_SHIFT) : 1;
    in_box = m_mode != 0 && h >= x && h < x + SPR_W * sc && v >= y && v < y + SPR_H * sc;
    e_on = 1'b0;
    if (in_box) begin
      m_addr = (v - y) / sc;
      e_on = rom[(v - y) / sc][(h - x) / sc] && m_bvis;
    end
    qa.push_back(m_addr);
    qo.push_back(e_on);
    if (fs) m_mode = !full_screen ? 1 : sprite_select ? 2 : 0;
    if (!blink_en) begin
      m_bcnt = 0;
      m_bvis = 1'b1;
    end else if (fs) begin
      m_bcnt++;
      if (m_bcnt == BLINK_FR) begin
        m_bcnt = 0;
        m_bvis = !m_bvis;
      end
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) pix(h, v, 1'b0);
  endtask

  task automatic vblank();
    for (int i = 0; i < 4; i++) pix(i, 500, 1'b0);
    pix(4, 500, 1'b1);
    for (int i = 5; i < 9; i++) pix(i, 500, 1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_sprite_on", int'(sprite_on), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    qa.delete();
    qo.delete();
    m_mode = 0;
    m_bcnt = 0;
    m_bvis = 1'b1;
    m_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rom_fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("por_sprite_on", int'(sprite_on), 0);
    chk("por_rom_addr", int'(rom_addr), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    line(26, 890, 960);
    vblank();
    line(100, 950, 1000);
    do_reset();
    line(26, 890, 960);
    vblank();
    line(26, 870, 1023);
    line(25, 890, 1023);
    line(170, 895, 1023);
    line(171, 895, 1023);
    line(26, 0, 80);
    full_screen = 1'b1;
    sprite_select = 1'b1;
    line(60, 890, 1000);
    vblank();
    rom_fill(2);
    for (int v = 172; v <= 175; v++) line(v, 210, 240);
    line(461, 210, 240);
    line(462, 600, 630);
    line(300, 600, 630);
    for (int it = 0; it < 24; it++) begin
      full_screen = 1'($urandom_range(0, 3) != 0);
      sprite_select = 1'($urandom_range(0, 3) != 0);
      vblank();
      rom_fill(1);
      for (int k = 0; k < 3; k++) begin
        int x0, y0, bw, bh, v, h0;
        x0 = full_screen ? FULL_X : THUMB_X;
        y0 = full_screen ? FULL_Y : THUMB_Y;
        bw = full_screen ? SPR_W << FULL_SHIFT : SPR_W;
        bh = full_screen ? SPR_H << FULL_SHIFT : SPR_H;
        v = y0 + $urandom_range(0, bh + 4) - 2;
        h0 = x0 + $urandom_range(0, bw) - 20;
        h0 = (h0 < 0) ? 0 : (h0 > 983) ? 983 : h0;
        line(v, h0, h0 + 40);
      end
    end
    full_screen = 1'b1;
    sprite_select = 1'b1;
    vblank();
    rom_fill(0);
    line(200, 215, 260);
    sprite_select = 1'b0;
    line(201, 215, 260);
    line(400, 600, 640);
    vblank();
    line(202, 215, 260);
    line(26, 890, 960);
    sprite_select = 1'b1;
    vblank();
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      vblank();
      line(172, 216, 226);
    end
    blink_en = 1'b0;
    vblank();
    line(172, 216, 226);
    for (int i = 0; i < 3; i++) pix(0, 500, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
